mandelbrot_point_generator: RTL and testbench
=============================================

Name: mandelbrot_point_generator

Overview:
- Computes the escape-time iteration count for one pixel of the Mandelbrot set.
- Maps pixel (x, y) to the complex point c = (re_start + x·re_scale) + i·(im_start + y·im_scale).
- Iterates z ← z² + c from z = 0 and reports the iteration count with a done flag.
- The rendering engine instantiates set_size copies, pulses start for one cycle, then waits for all done flags.

Parameters:
- HBP, 32: fixed-point width control. Operands are signed Q4.(HBP-3): HBP+1 bits total, 4 integer bits including sign.
- HBI, 32: width of the iteration output.
- MAX_ITERATIONS, 255: iteration cap. A point that never escapes reports this value.

Ports:
- CLK  in  1  system clock, rising edge.
- SYS_RESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a point.
- re_scale  in  HBP+1  signed Q4.(HBP-3), real step per x pixel.
- im_scale  in  HBP+1  signed Q4.(HBP-3), imaginary step per y pixel.
- x  in  12  unsigned pixel column.
- y  in  12  unsigned pixel row.
- re_start  in  HBP+1  signed Q4.(HBP-3), real coordinate of pixel (0,0).
- im_start  in  HBP+1  signed Q4.(HBP-3), imaginary coordinate of pixel (0,0).
- done  out  1  high when idle or finished; low while computing.
- iteration  out  HBI  result count, zero-extended.

Behaviour:
- Reset (asynchronous): state IDLE, done=1, iteration=0, z=0, count=0.
- States: IDLE → SETUP → ITER → IDLE.
- IDLE, start=1 at edge N:
  - latch x, y, re_start, im_start, re_scale, im_scale.
  - done<=0 at that same edge (engine samples done on the next cycle).
  - go to SETUP.
- SETUP, edge N+1:
  - c_re = re_start + x·re_scale; c_im = im_start + y·im_scale.
  - x and y are treated as non-negative integers; product truncated to Q4.(HBP-3), integer bits wrap.
  - z_re = z_im = 0, count = 0; go to ITER.
- ITER, one check per clock, evaluated on the current z:
  - Compute zr² and zi² with 8 integer bits (no overflow for |z| < 11).
  - If zr² + zi² > 4.0 (strict): iteration<=count, done<=1, go to IDLE.
  - Else if count == MAX_ITERATIONS: iteration<=MAX_ITERATIONS, done<=1, go to IDLE.
  - Else: z_re <= zr² − zi² + c_re; z_im <= 2·zr·zi + c_im (truncated to Q4 format); count<=count+1.
- Latency: done rises at edge N+2+k, where k is the reported iteration value.
- Multiplies use an internal signed fixed-point multiplier with generics iD, iF, oD, oF:
  - full-precision signed product.
  - fraction truncated by arithmetic right shift (toward −∞).
  - low oD integer bits kept (wrap).
- iteration holds its value until the next accepted start. It is not cleared when start is accepted.
- start while not IDLE is ignored; inputs may change freely after the start edge.
- Reset mid-computation aborts immediately to the reset state.

Optional Feature:
- Macro PG_BULB_SKIP_EN.
- Defined: on leaving SETUP, if (c_re+1)² + c_im² < 0.0625 (period-2 bulb), skip ITER. iteration<=MAX_ITERATIONS and done<=1 at edge N+2.
- Undefined: every point goes through normal ITER.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then release with no start → done=1, iteration=0; start pulse during reset has no effect.
- re_start=1.0, im_start=0, scales 0, x=y=0, start at edge N → done=0 after N, iteration=3, done=1 after N+5.
- c=2.0+0i → iteration=2. c=−2.0+0i → iteration=255, done after N+257 (|z|²=4 never escapes, strict compare).
- re_start=−2.0, re_scale=2⁻⁸, x=512, im_start=−1.0, im_scale=2⁻⁸, y=256 (c=0) → iteration=255. Repeat with PG_BULB_SKIP_EN and c=−1 → 255 after N+2.
- Second start pulse mid-computation → ignored, result unchanged. Assert SYS_RESET mid-ITER → done=1, iteration=0 immediately (asynchronous).
- Back-to-back points with start the cycle after done rises → each result correct; iteration holds the prior value until the new done.

Source files
------------

// File: rtl/mandelbrot_point_generator.sv
// Escape-time Mandelbrot iteration engine for a single pixel, signed Q4.(HBP-3) arithmetic.
// Optional macro PG_BULB_SKIP_EN: points inside the period-2 bulb finish right after SETUP.
module mandelbrot_point_generator #(
  parameter int HBP            = 32,
  parameter int HBI            = 32,
  parameter int MAX_ITERATIONS = 255
) (
  input  logic           CLK,
  input  logic           SYS_RESET,
  input  logic           start,
  input  logic [HBP:0]   re_scale,
  input  logic [HBP:0]   im_scale,
  input  logic [11:0]    x,
  input  logic [11:0]    y,
  input  logic [HBP:0]   re_start,
  input  logic [HBP:0]   im_start,
  output logic           done,
  output logic [HBI-1:0] iteration
);

  localparam int W     = HBP + 1;
  localparam int F     = HBP - 3;
  localparam int FX_ID = 5;
  localparam int FX_IF = F;
  localparam int FX_OD = 8;
  localparam int FX_OF = F;
  localparam int MW    = FX_ID + FX_IF;
  localparam int SQ_W  = FX_OD + FX_OF;
  localparam int CNT_W = $clog2(MAX_ITERATIONS + 1);

  localparam logic signed [SQ_W:0] FOUR = {{(SQ_W - F - 2){1'b0}}, 3'b100, {F{1'b0}}};

  typedef enum logic [1:0] {IDLE, SETUP, ITER} state_t;

  // Signed fixed-point multiply: full product, arithmetic shift drops fraction, low integer bits wrap.
  function automatic logic signed [SQ_W-1:0] fx_mul(input logic signed [MW-1:0] a,
                                                     input logic signed [MW-1:0] b);
    logic signed [2*MW-1:0] full;
    full = (2*MW)'(a) * (2*MW)'(b);
    return SQ_W'(full >>> (2*FX_IF - FX_OF));
  endfunction

  state_t               state_q, state_d;
  logic                 done_q, done_d;
  logic [HBI-1:0]       iteration_q, iteration_d;
  logic signed [W-1:0]  z_re_q, z_re_d, z_im_q, z_im_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic signed [W-1:0]  c_re_q, c_re_d, c_im_q, c_im_d;
  logic signed [W-1:0]  re_start_q, im_start_q, re_scale_q, im_scale_q;
  logic [11:0]          x_q, y_q;
  logic                 lat_en;

  logic signed [W-1:0]    xs, ys;
  logic signed [SQ_W-1:0] zr2, zi2, zrzi;
  logic signed [SQ_W:0]   mag;
  logic                   skip;

  assign xs   = {{(W-12){1'b0}}, x_q};
  assign ys   = {{(W-12){1'b0}}, y_q};
  assign zr2  = fx_mul(MW'(z_re_q), MW'(z_re_q));
  assign zi2  = fx_mul(MW'(z_im_q), MW'(z_im_q));
  assign zrzi = fx_mul(MW'(z_re_q), MW'(z_im_q));
  assign mag  = (SQ_W+1)'(zr2) + (SQ_W+1)'(zi2);

`ifdef PG_BULB_SKIP_EN
  localparam logic signed [MW-1:0] ONE_M     = {{(MW-F-1){1'b0}}, 1'b1, {F{1'b0}}};
  localparam logic signed [SQ_W:0] SIXTEENTH = {{(SQ_W-F+4){1'b0}}, 1'b1, {(F-4){1'b0}}};
  logic signed [MW-1:0] cp1;
  logic signed [SQ_W:0] bulb_mag;
  assign cp1      = MW'(c_re_q) + ONE_M;
  assign bulb_mag = (SQ_W+1)'(fx_mul(cp1, cp1)) + (SQ_W+1)'(fx_mul(MW'(c_im_q), MW'(c_im_q)));
  // The bulb test runs on the first ITER cycle, which is the first cycle c is registered.
  assign skip     = (bulb_mag < SIXTEENTH) && (count_q == '0);
`else
  assign skip     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    iteration_d = iteration_q;
    z_re_d      = z_re_q;
    z_im_d      = z_im_q;
    count_d     = count_q;
    c_re_d      = c_re_q;
    c_im_d      = c_im_q;
    lat_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          lat_en  = 1'b1;
          done_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        c_re_d  = re_start_q + xs * re_scale_q;
        c_im_d  = im_start_q + ys * im_scale_q;
        z_re_d  = '0;
        z_im_d  = '0;
        count_d = '0;
        state_d = ITER;
      end
      ITER: begin
        if (skip || (mag <= FOUR && count_q == CNT_W'(MAX_ITERATIONS))) begin
          iteration_d = HBI'(MAX_ITERATIONS);
          done_d      = 1'b1;
          state_d     = IDLE;
        end else if (mag > FOUR) begin
          iteration_d = HBI'(count_q);
          done_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          z_re_d  = W'(zr2 - zi2) + c_re_q;
          z_im_d  = W'(zrzi <<< 1) + c_im_q;
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      state_q     <= IDLE;
      done_q      <= 1'b1;
      iteration_q <= '0;
      z_re_q      <= '0;
      z_im_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      iteration_q <= iteration_d;
      z_re_q      <= z_re_d;
      z_im_q      <= z_im_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (lat_en) begin
      x_q        <= x;
      y_q        <= y;
      re_start_q <= $signed(re_start);
      im_start_q <= $signed(im_start);
      re_scale_q <= $signed(re_scale);
      im_scale_q <= $signed(im_scale);
    end
    c_re_q <= c_re_d;
    c_im_q <= c_im_d;
  end

  assign done      = done_q;
  assign iteration = iteration_q;

endmodule

// File: tb/tb_mandelbrot_point_generator.sv
// Directed bench for mandelbrot_point_generator: hand-computed iteration counts and latencies.
module tb_mandelbrot_point_generator;
  localparam int HBP = 32;
  localparam int HBI = 32;
  localparam int W   = HBP + 1;
  localparam int F   = HBP - 3;
`ifdef PG_BULB_SKIP_EN
  localparam int BULB_LAT = 2;
`else
  localparam int BULB_LAT = 257;
`endif

  logic           CLK = 1'b0;
  logic           SYS_RESET = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   re_scale = '0, im_scale = '0, re_start = '0, im_start = '0;
  logic [11:0]    x = '0, y = '0;
  logic           done;
  logic [HBI-1:0] iteration;
  logic [HBI-1:0] last = '0;
  int n_vec = 0;
  int n_err = 0;

  mandelbrot_point_generator #(.HBP(HBP), .HBI(HBI), .MAX_ITERATIONS(255)) dut (
    .CLK(CLK), .SYS_RESET(SYS_RESET), .start(start),
    .re_scale(re_scale), .im_scale(im_scale), .x(x), .y(y),
    .re_start(re_start), .im_start(im_start),
    .done(done), .iteration(iteration)
  );

  always #5 CLK = ~CLK;

  // Value v/256 in Q4.(HBP-3).
  function automatic logic [W-1:0] q(input int v);
    longint t;
    t = longint'(v) <<< (F - 8);
    return W'(t);
  endfunction

  task automatic launch(input int rs, input int is, input int rsc, input int isc,
                        input int xx, input int yy, input bit now);
    if (!now) @(negedge CLK);
    re_start = q(rs); im_start = q(is); re_scale = q(rsc); im_scale = q(isc);
    x = 12'(xx); y = 12'(yy); start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    re_start = q(999); im_start = q(-999); re_scale = q(77); im_scale = q(-55);
    x = 12'hABC; y = 12'h123;
  endtask

  task automatic finish_wait(input string name, input int exp_iter, input int exp_lat,
                             input int poke);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 0;
    @(negedge CLK);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL %s done_after_start: got %b want 0", name, done);
    end
    n_vec++;
    if (iteration !== last) begin
      n_err++; $display("FAIL %s hold: got %0d want %0d", name, iteration, last);
    end
    for (int i = 1; i <= exp_lat + 20 && !seen; i++) begin
      if (i == poke) begin
        re_start = q(512); start = 1'b1;
      end
      @(posedge CLK);
      #1 start = 1'b0;
      @(negedge CLK);
      if (done === 1'b1) begin
        seen = 1; cyc = i;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL %s timeout: no done within %0d cycles", name, exp_lat + 20);
    end else if (cyc != exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
    end
    n_vec++;
    if (iteration !== HBI'(exp_iter)) begin
      n_err++; $display("FAIL %s iteration: got %0d want %0d", name, iteration, exp_iter);
    end
    last = HBI'(exp_iter);
  endtask

  task automatic test_reset();
    SYS_RESET = 1'b1;
    repeat (2) @(negedge CLK);
    re_start = q(256); start = 1'b1;
    repeat (2) @(negedge CLK);
    start = 1'b0;
    n_vec++;
    if (done !== 1'b1 || iteration !== '0) begin
      n_err++; $display("FAIL reset_held: got done=%b iter=%0d want 1/0", done, iteration);
    end
    SYS_RESET = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL reset_idle_done: got %b want 1", done);
    end
    n_vec++;
    if (iteration !== '0) begin
      n_err++; $display("FAIL reset_idle_iter: got %0d want 0", iteration);
    end
    last = '0;
  endtask

  task automatic test_points();
    launch(256, 0, 0, 0, 0, 0, 0);      finish_wait("c_1",       3,   5,   0);
    launch(512, 0, 0, 0, 0, 0, 0);      finish_wait("c_2",       2,   4,   0);
    launch(-512, 0, 0, 0, 0, 0, 0);     finish_wait("c_m2",      255, 257, 0);
    launch(-512, -256, 1, 1, 512, 256, 0); finish_wait("c_0_scaled", 255, 257, 0);
    launch(128, 0, 0, 0, 0, 0, 0);      finish_wait("c_half",    5,   7,   0);
    launch(0, 256, 0, 0, 0, 0, 0);      finish_wait("c_i",       255, 257, 0);
    launch(0, 512, 0, 0, 0, 0, 0);      finish_wait("c_2i",      2,   4,   0);
    launch(256, 0, 0, 1, 0, 256, 0);    finish_wait("c_1p_i_y",  2,   4,   0);
    launch(768, 0, -1, 0, 256, 0, 0);   finish_wait("c_2_negsc", 2,   4,   0);
  endtask

  task automatic test_bulb();
    launch(-512, 0, 1, 1, 256, 0, 0);   finish_wait("c_m1_bulb", 255, BULB_LAT, 0);
  endtask

  task automatic test_ignore_start();
    launch(128, 0, 0, 0, 0, 0, 0);      finish_wait("ignore_start", 5, 7, 3);
  endtask

  task automatic test_reset_mid();
    launch(0, 0, 0, 0, 0, 0, 0);
    repeat (10) @(posedge CLK);
    #3 SYS_RESET = 1'b1;
    #1;
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_done: got %b want 1", done);
    end
    n_vec++;
    if (iteration !== '0) begin
      n_err++; $display("FAIL reset_mid_iter: got %0d want 0", iteration);
    end
    @(negedge CLK);
    SYS_RESET = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_after: got %b want 1", done);
    end
    last = '0;
  endtask

  task automatic test_back_to_back();
    launch(256, 0, 0, 0, 0, 0, 0);      finish_wait("b2b_first",  3, 5, 0);
    launch(512, 0, 0, 0, 0, 0, 1);      finish_wait("b2b_second", 2, 4, 0);
    launch(128, 0, 0, 0, 0, 0, 1);      finish_wait("b2b_third",  5, 7, 0);
  endtask

  initial begin
    test_reset();
    test_points();
    test_bulb();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
